// File: rtl/uart_rx_core.sv
// Parametrised UART receiver: 2-flop synchroniser, mid-bit oversampling FSM, frame/parity flags.
// Define UART_RX_FIFO_EN to buffer accepted bytes in a FIFO_DEPTH-entry valid/ready FIFO.
module uart_rx_core #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 uart_rx,
  input  logic                 rx_ready,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int unsigned Div  = CLK_FREQ / BAUD;
  localparam int unsigned Half = Div / 2;
  localparam int unsigned CntW = (Div > 2) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] DivM1  = CntW'(Div - 1);
  localparam logic [CntW-1:0] HalfM1 = CntW'(Half - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  logic                 sync1_q, sync2_q, prev_q;
  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 stop_ok_q, stop_ok_d;
  logic                 stop_idx_q, stop_idx_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 fall, tick, rxs, last_stop, stop_good, par_calc, par_bad, accept;

  assign rxs  = sync2_q;
  assign fall = prev_q & ~sync2_q;
  assign tick = (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    stop_ok_d  = stop_ok_q;
    stop_idx_d = stop_idx_q;
    last_stop  = 1'b0;
    if (state_q != StIdle) begin
      cnt_d = tick ? DivM1 : cnt_q - CntW'(1);
    end
    unique case (state_q)
      StIdle: begin
        if (fall) begin
          cnt_d   = HalfM1;
          state_d = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          // A high mid-bit sample means the edge was a glitch: drop silently.
          state_d    = rxs ? StIdle : StData;
          bit_d      = '0;
          stop_idx_d = 1'b0;
          stop_ok_d  = 1'b1;
        end
      end
      StData: begin
        if (tick) begin
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 4'd1;
          if (bit_q == 4'(DATA_BITS - 1)) begin
            state_d = (PARITY != 0) ? StParity : StStop;
          end
        end
      end
      StParity: begin
        if (tick) begin
          par_d   = rxs;
          state_d = StStop;
        end
      end
      StStop: begin
        if (tick) begin
          stop_ok_d = stop_ok_q & rxs;
          if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            last_stop = 1'b1;
            state_d   = StIdle;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    stop_good    = stop_ok_q & rxs;
    par_calc     = (^shift_q) ^ par_q;
    par_bad      = (PARITY == 1) ? par_calc : (PARITY == 2) ? ~par_calc : 1'b0;
    frame_err_d  = last_stop & ~stop_good;
    parity_err_d = last_stop & stop_good & par_bad;
    accept       = last_stop & stop_good & ~par_bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      prev_q       <= 1'b1;
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      stop_ok_q    <= 1'b0;
      stop_idx_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      sync1_q      <= uart_rx;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      stop_ok_q    <= stop_ok_d;
      stop_idx_q   <= stop_idx_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;

`ifdef UART_RX_FIFO_EN
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PtrW:0]        count_q, count_d;
  logic                 overrun_q, overrun_d;
  logic                 pop, full, push;

  always_comb begin
    pop       = (count_q != '0) && rx_ready;
    full      = (count_q == (PtrW + 1)'(FIFO_DEPTH));
    // A simultaneous pop frees the slot, so a full FIFO still takes the byte.
    push      = accept && (!full || pop);
    overrun_d = accept && full && !pop;
    wptr_d    = push ? wptr_q + PtrW'(1) : wptr_q;
    rptr_d    = pop ? rptr_q + PtrW'(1) : rptr_q;
    count_d   = count_q;
    if (push && !pop) begin
      count_d = count_q + (PtrW + 1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= shift_q;
      end
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  assign rx_valid = (count_q != '0);
  assign rx_data  = mem_q[rptr_q];
  assign overrun  = overrun_q;
`else
  logic                 valid_q;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 unused_rx_ready;

  assign unused_rx_ready = rx_ready;

  always_comb begin
    data_d = accept ? shift_q : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= accept;
      data_q  <= data_d;
    end
  end

  assign rx_valid = valid_q;
  assign rx_data  = data_q;
  assign overrun  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: three instances (8N1 @ DIV 434, 8E1 @ DIV 16, 7O2 @ DIV 16).
`timescale 1ns/1ps
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line0 = 1'b1, line1 = 1'b1, line2 = 1'b1;
  logic       rdy0 = 1'b1, rdy1 = 1'b1, rdy2 = 1'b1;
  logic       v0, v1, v2, f0, f1, f2, p0, p1, p2, o0, o1, o2;
  logic [7:0] d0, d1;
  logic [6:0] d2;

  int         tests = 0;
  int         fails = 0;
  int         nv[3], nf[3], np[3], nov[3];
  logic [8:0] ld[3];
  logic [8:0] q1[$];

  always #5 clk = ~clk;

  uart_rx_core u_dut0 (
    .clk(clk), .rst_n(rst_n), .uart_rx(line0), .rx_ready(rdy0), .rx_valid(v0), .rx_data(d0),
    .frame_err(f0), .parity_err(p0), .overrun(o0)
  );
  uart_rx_core #(.BAUD(3_125_000), .PARITY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .uart_rx(line1), .rx_ready(rdy1), .rx_valid(v1), .rx_data(d1),
    .frame_err(f1), .parity_err(p1), .overrun(o1)
  );
  uart_rx_core #(.BAUD(3_125_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .uart_rx(line2), .rx_ready(rdy2), .rx_valid(v2), .rx_data(d2),
    .frame_err(f2), .parity_err(p2), .overrun(o2)
  );

  initial begin
    for (int i = 0; i < 3; i++) begin
      nv[i] = 0; nf[i] = 0; np[i] = 0; nov[i] = 0; ld[i] = '0;
    end
  end

  // Count every high cycle of each output so pulse width is checked too.
  always @(negedge clk) begin
    if (v0) begin nv[0] = nv[0] + 1; ld[0] = {1'b0, d0}; end
    if (v1) begin nv[1] = nv[1] + 1; ld[1] = {1'b0, d1}; q1.push_back({1'b0, d1}); end
    if (v2) begin nv[2] = nv[2] + 1; ld[2] = {2'b0, d2}; end
    if (f0) nf[0] = nf[0] + 1;
    if (f1) nf[1] = nf[1] + 1;
    if (f2) nf[2] = nf[2] + 1;
    if (p0) np[0] = np[0] + 1;
    if (p1) np[1] = np[1] + 1;
    if (p2) np[2] = np[2] + 1;
    if (o0) nov[0] = nov[0] + 1;
    if (o1) nov[1] = nov[1] + 1;
    if (o2) nov[2] = nov[2] + 1;
  end

  task automatic drive(input int w, input logic v);
    case (w)
      0: line0 = v;
      1: line1 = v;
      default: line2 = v;
    endcase
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // sv[0] is the first stop bit; the last stop bit lasts last_len cycles.
  task automatic send(input int w, input int div, input logic [8:0] d, input int nb,
                      input bit has_p, input logic pb, input int ns, input logic [1:0] sv,
                      input int last_len);
    drive(w, 1'b0); wait_cyc(div);
    for (int i = 0; i < nb; i++) begin drive(w, d[i]); wait_cyc(div); end
    if (has_p) begin drive(w, pb); wait_cyc(div); end
    for (int i = 0; i < ns; i++) begin
      drive(w, sv[i]);
      wait_cyc((i == ns - 1) ? last_len : div);
    end
  endtask

  task automatic test_reset;
    wait_cyc(3);
    tests++; if ({v0, f0, p0, o0} !== 4'b0) begin fails++;
      $display("FAIL reset_flags0: got %b want 0000", {v0, f0, p0, o0}); end
    tests++; if (d0 !== 8'h00) begin fails++; $display("FAIL reset_data0: got %h want 00", d0); end
    tests++; if ({v1, f1, p1, o1, v2, f2, p2, o2} !== 8'b0) begin fails++;
      $display("FAIL reset_flags12: got %b want 0", {v1, f1, p1, o1, v2, f2, p2, o2}); end
    tests++; if ({d1, d2} !== 15'b0) begin fails++;
      $display("FAIL reset_data12: got %h want 0", {d1, d2}); end
    rst_n = 1'b1;
    wait_cyc(5);
  endtask

  task automatic test_basic;
    int bv = nv[0], bf = nf[0], bp = np[0];
    send(0, 434, 9'h0A5, 8, 1'b0, 1'b0, 1, 2'b11, 434);
    wait_cyc(434);
    tests++; if (nv[0] - bv !== 1) begin fails++;
      $display("FAIL basic_valid_cycles: got %0d want 1", nv[0] - bv); end
    tests++; if (ld[0] !== 9'h0A5) begin fails++; $display("FAIL basic_data: got %h want a5", ld[0]); end
    tests++; if ((nf[0] - bf) + (np[0] - bp) !== 0) begin fails++;
      $display("FAIL basic_flags: got %0d want 0", (nf[0] - bf) + (np[0] - bp)); end
  endtask

  task automatic test_false_start;
    int bv = nv[0], bf = nf[0], bp = np[0];
    drive(0, 1'b0); wait_cyc(100);
    drive(0, 1'b1); wait_cyc(868);
    tests++; if ((nv[0] - bv) + (nf[0] - bf) + (np[0] - bp) !== 0) begin fails++;
      $display("FAIL glitch_quiet: got %0d events want 0", (nv[0] - bv) + (nf[0] - bf) + (np[0] - bp)); end
    send(0, 434, 9'h0C3, 8, 1'b0, 1'b0, 1, 2'b11, 434);
    wait_cyc(434);
    tests++; if (nv[0] - bv !== 1 || ld[0] !== 9'h0C3) begin fails++;
      $display("FAIL glitch_recover: got %0d/%h want 1/c3", nv[0] - bv, ld[0]); end
  endtask

  task automatic test_frame_err;
    int bv = nv[0], bf = nf[0], bp = np[0];
    send(0, 434, 9'h03C, 8, 1'b0, 1'b0, 1, 2'b00, 434);
    drive(0, 1'b1); wait_cyc(434);
    tests++; if (nf[0] - bf !== 1) begin fails++;
      $display("FAIL frame_err_pulse: got %0d want 1", nf[0] - bf); end
    tests++; if ((nv[0] - bv) + (np[0] - bp) !== 0) begin fails++;
      $display("FAIL frame_err_other: got %0d want 0", (nv[0] - bv) + (np[0] - bp)); end
`ifndef UART_RX_FIFO_EN
    tests++; if (d0 !== 8'hC3) begin fails++; $display("FAIL frame_err_hold: got %h want c3", d0); end
`endif
  endtask

  task automatic test_parity;
    int bv = nv[1], bf = nf[1], bp = np[1];
    send(1, 16, 9'h007, 8, 1'b1, 1'b0, 1, 2'b11, 16);
    wait_cyc(32);
    tests++; if (np[1] - bp !== 1 || nv[1] - bv !== 0 || nf[1] - bf !== 0) begin fails++;
      $display("FAIL parity_bad: got p%0d v%0d f%0d want p1 v0 f0", np[1] - bp, nv[1] - bv, nf[1] - bf); end
    send(1, 16, 9'h007, 8, 1'b1, 1'b1, 1, 2'b11, 16);
    wait_cyc(32);
    tests++; if (nv[1] - bv !== 1 || ld[1] !== 9'h007 || np[1] - bp !== 1) begin fails++;
      $display("FAIL parity_good: got v%0d d%h p%0d want v1 d07 p1", nv[1] - bv, ld[1], np[1] - bp); end
  endtask

  // 7 data bits, odd parity, 2 stop bits: 0x5A has four ones, so the parity bit is 1.
  task automatic test_format;
    int bv = nv[2], bf = nf[2], bp = np[2];
    send(2, 16, 9'h05A, 7, 1'b1, 1'b1, 2, 2'b11, 16); wait_cyc(32);
    tests++; if (nv[2] - bv !== 1 || ld[2] !== 9'h05A) begin fails++;
      $display("FAIL fmt_good: got v%0d d%h want v1 d5a", nv[2] - bv, ld[2]); end
    send(2, 16, 9'h05A, 7, 1'b1, 1'b0, 2, 2'b11, 16); wait_cyc(32);
    tests++; if (np[2] - bp !== 1 || nv[2] - bv !== 1) begin fails++;
      $display("FAIL fmt_parity: got p%0d v%0d want p1 v1", np[2] - bp, nv[2] - bv); end
    send(2, 16, 9'h05A, 7, 1'b1, 1'b1, 2, 2'b01, 16); drive(2, 1'b1); wait_cyc(32);
    tests++; if (nf[2] - bf !== 1 || nv[2] - bv !== 1) begin fails++;
      $display("FAIL fmt_stop2: got f%0d v%0d want f1 v1", nf[2] - bf, nv[2] - bv); end
    send(2, 16, 9'h05A, 7, 1'b1, 1'b0, 2, 2'b10, 16); wait_cyc(32);
    tests++; if (nf[2] - bf !== 2 || np[2] - bp !== 1) begin fails++;
      $display("FAIL fmt_frame_wins: got f%0d p%0d want f2 p1", nf[2] - bf, np[2] - bp); end
  endtask

  task automatic test_break;
    int bv = nv[1], bf = nf[1];
    drive(1, 1'b0); wait_cyc(16 * 30);
    drive(1, 1'b1); wait_cyc(32);
    tests++; if (nf[1] - bf !== 1 || nv[1] - bv !== 0) begin fails++;
      $display("FAIL break_once: got f%0d v%0d want f1 v0", nf[1] - bf, nv[1] - bv); end
    send(1, 16, 9'h081, 8, 1'b1, 1'b0, 1, 2'b11, 16); wait_cyc(32);
    tests++; if (nv[1] - bv !== 1 || ld[1] !== 9'h081) begin fails++;
      $display("FAIL break_recover: got v%0d d%h want v1 d81", nv[1] - bv, ld[1]); end
  endtask

  // Second start edge lands in the back half of the first frame's stop bit.
  task automatic test_back_to_back;
    int bf = nf[1], bp = np[1];
    q1.delete();
    send(1, 16, 9'h012, 8, 1'b1, 1'b0, 1, 2'b11, 12);
    send(1, 16, 9'h034, 8, 1'b1, 1'b1, 1, 2'b11, 16);
    wait_cyc(32);
    tests++; if (q1.size() !== 2) begin fails++;
      $display("FAIL b2b_count: got %0d want 2", q1.size()); end
    else begin
      tests++; if (q1[0] !== 9'h012 || q1[1] !== 9'h034) begin fails++;
        $display("FAIL b2b_data: got %h,%h want 12,34", q1[0], q1[1]); end
    end
    tests++; if ((nf[1] - bf) + (np[1] - bp) !== 0) begin fails++;
      $display("FAIL b2b_flags: got %0d want 0", (nf[1] - bf) + (np[1] - bp)); end
  endtask

  task automatic test_reset_mid;
    int bv = nv[0], bf = nf[0], bp = np[0];
    logic [7:0] pat = 8'h55;
    drive(0, 1'b0); wait_cyc(434);
    for (int i = 0; i < 3; i++) begin drive(0, pat[i]); wait_cyc(434); end
    drive(0, pat[3]); wait_cyc(200);
    rst_n = 1'b0; drive(0, 1'b1); wait_cyc(5);
    rst_n = 1'b1; wait_cyc(868);
    tests++; if (nv[0] - bv !== 0) begin fails++;
      $display("FAIL rst_mid_abort: got %0d valid want 0", nv[0] - bv); end
    send(0, 434, 9'h081, 8, 1'b0, 1'b0, 1, 2'b11, 434); wait_cyc(434);
    tests++; if (nv[0] - bv !== 1 || ld[0] !== 9'h081) begin fails++;
      $display("FAIL rst_mid_next: got v%0d d%h want v1 d81", nv[0] - bv, ld[0]); end
    tests++; if ((nf[0] - bf) + (np[0] - bp) !== 0) begin fails++;
      $display("FAIL rst_mid_flags: got %0d want 0", (nf[0] - bf) + (np[0] - bp)); end
  endtask

`ifdef UART_RX_FIFO_EN
  task automatic test_fifo;
    int bo = nov[1];
    logic [7:0] b;
    rdy1 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      b = 8'(k);
      send(1, 16, {1'b0, b}, 8, 1'b1, ^b, 1, 2'b11, 16);
      wait_cyc(8);
      if (k == 4) begin
        tests++; if (nov[1] - bo !== 0) begin fails++;
          $display("FAIL fifo_no_ovr: got %0d want 0", nov[1] - bo); end
      end
    end
    tests++; if (nov[1] - bo !== 1) begin fails++;
      $display("FAIL fifo_overrun: got %0d want 1", nov[1] - bo); end
    for (int k = 1; k <= 4; k++) begin
      tests++; if (v1 !== 1'b1 || d1 !== 8'(k)) begin fails++;
        $display("FAIL fifo_pop%0d: got v%b d%h want v1 d%h", k, v1, d1, 8'(k)); end
      rdy1 = 1'b1; wait_cyc(1); rdy1 = 1'b0;
    end
    tests++; if (v1 !== 1'b0) begin fails++; $display("FAIL fifo_empty: got %b want 0", v1); end
    rdy1 = 1'b1;
  endtask
`else
  task automatic test_no_overrun;
    tests++; if (nov[0] + nov[1] + nov[2] !== 0) begin fails++;
      $display("FAIL overrun_tied: got %0d want 0", nov[0] + nov[1] + nov[2]); end
  endtask
`endif

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset;
    test_basic;
    test_false_start;
    test_frame_err;
    test_parity;
    test_format;
    test_break;
    test_back_to_back;
    test_reset_mid;
`ifdef UART_RX_FIFO_EN
    test_fifo;
`else
    test_no_overrun;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
